// File: rtl/avg_channel_scheduler.sv
// Round-robin scheduler sharing one 2^DEPTH_LOG2-deep moving-average engine among NCH requesters.
// Optional feature: define AVG_SCHED_PRIME_EN to prime a channel's whole history with its first sample.
module avg_channel_scheduler #(
  parameter int NCH        = 4,
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCH-1:0]           REQ,
  input  logic [NCH*W-1:0]         SAMPLE,
  output logic [NCH-1:0]           ACK,
  output logic                     AVG_VALID,
  input  logic                     AVG_READY,
  output logic [$clog2(NCH)-1:0]   AVG_CH,
  output logic [W-1:0]             AVG_OUT,
  output logic [NCH-1:0]           FILL
);

  localparam int CHW   = $clog2(NCH);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = W + DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, UPDATE, OUT} state_t;

  state_t                state_q, state_d;
  logic [CHW-1:0]        sel_q, sel_d;
  logic [W-1:0]          sample_q, sample_d;
  logic [NCH-1:0]        ack_q, ack_d;
  logic [NCH-1:0]        fill_q, fill_d;
  logic                  avg_valid_q, avg_valid_d;
  logic [CHW-1:0]        avg_ch_q, avg_ch_d;
  logic [W-1:0]          avg_out_q, avg_out_d;
  logic [W-1:0]          ring_q [NCH][DEPTH];
  logic [W-1:0]          ring_d [NCH][DEPTH];
  logic [SW-1:0]         sum_q [NCH];
  logic [SW-1:0]         sum_d [NCH];
  logic [DEPTH_LOG2-1:0] ptr_q [NCH];
  logic [DEPTH_LOG2-1:0] ptr_d [NCH];
  logic [CW-1:0]         cnt_q [NCH];
  logic [CW-1:0]         cnt_d [NCH];

  logic                  found;
  logic [CHW-1:0]        pick;
  logic [CHW:0]          cand;
  logic [W-1:0]          old_v;
  logic [SW-1:0]         sum_new;
  logic [CW-1:0]         cnt_new;

  // Search upward from the channel after the last grant, wrapping at NCH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, sel_q} + (CHW+1)'(k + 1);
      if (cand >= (CHW+1)'(NCH)) cand = cand - (CHW+1)'(NCH);
      if (!found && REQ[cand[CHW-1:0]]) begin
        found = 1'b1;
        pick  = cand[CHW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sample_d    = sample_q;
    ack_d       = '0;
    fill_d      = fill_q;
    avg_valid_d = avg_valid_q;
    avg_ch_d    = avg_ch_q;
    avg_out_d   = avg_out_q;
    ring_d      = ring_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    old_v   = ring_q[sel_q][ptr_q[sel_q]];
    sum_new = sum_q[sel_q] - SW'(old_v) + SW'(sample_q);
    cnt_new = (cnt_q[sel_q] == CW'(DEPTH)) ? cnt_q[sel_q] : cnt_q[sel_q] + 1'b1;
`ifdef AVG_SCHED_PRIME_EN
    if (cnt_q[sel_q] == '0) begin
      sum_new = SW'(sample_q) << DEPTH_LOG2;
      cnt_new = CW'(DEPTH);
    end
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d       = pick;
          sample_d    = SAMPLE[pick*W +: W];
          ack_d[pick] = 1'b1;
          state_d     = UPDATE;
        end
      end
      UPDATE: begin
        ring_d[sel_q][ptr_q[sel_q]] = sample_q;
`ifdef AVG_SCHED_PRIME_EN
        if (cnt_q[sel_q] == '0) begin
          for (int d = 0; d < DEPTH; d++) ring_d[sel_q][d] = sample_q;
        end
`endif
        sum_d[sel_q] = sum_new;
        ptr_d[sel_q] = ptr_q[sel_q] + 1'b1;
        cnt_d[sel_q] = cnt_new;
        if (cnt_new == CW'(DEPTH)) fill_d[sel_q] = 1'b1;
        avg_out_d   = sum_new[SW-1:DEPTH_LOG2];
        avg_ch_d    = sel_q;
        avg_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (AVG_READY) begin
          avg_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sel_q doubles as the last-grant pointer, so reset points it at NCH-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      sel_q       <= CHW'(NCH - 1);
      sample_q    <= '0;
      ack_q       <= '0;
      fill_q      <= '0;
      avg_valid_q <= 1'b0;
      avg_ch_q    <= '0;
      avg_out_q   <= '0;
      ring_q      <= '{default: '{default: '0}};
      sum_q       <= '{default: '0};
      ptr_q       <= '{default: '0};
      cnt_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sample_q    <= sample_d;
      ack_q       <= ack_d;
      fill_q      <= fill_d;
      avg_valid_q <= avg_valid_d;
      avg_ch_q    <= avg_ch_d;
      avg_out_q   <= avg_out_d;
      ring_q      <= ring_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ACK       = ack_q;
  assign FILL      = fill_q;
  assign AVG_VALID = avg_valid_q;
  assign AVG_CH    = avg_ch_q;
  assign AVG_OUT   = avg_out_q;

endmodule
